interrupt_dispatcher: RTL and testbench
=======================================

# interrupt_dispatcher

Sequences processor entry into and exit from interrupt handlers. It sits between the interrupt decider and the processor state register. On a decided interrupt it waits for an instruction boundary, then saves the processor state on a nesting stack, issues the start acknowledge to the interrupt controller and presents the vector address. On return-from-interrupt it restores the saved state and issues the end acknowledge.

## Interface
- `ID_W`, 5, interrupt ID width
- `PRI_W`, 3, priority width
- `ADDR_W`, 28, vector address width
- `DEPTH`, 4, maximum nesting depth (≥1)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `irq_valid`  in  1  decided interrupt pending (decider `int_flag_out`)
- `irq_id`  in  ID_W  pending interrupt ID
- `irq_priority`  in  PRI_W  pending interrupt priority
- `ivt_addr`  in  ADDR_W  vector address for `irq_id`
- `p_state_in`  in  32  live processor state: [0] gie, [5:1] current ID, [8:6] current priority
- `fetch_ready`  in  1  processor at instruction boundary
- `reti`  in  1  one-cycle pulse: return-from-interrupt executed
- `ack_start`, `ack_start_id`  out  1, ID_W  start acknowledge to controller
- `ack_end`, `ack_end_id`  out  1, ID_W  end acknowledge to controller
- `p_state_load`, `p_state_out`  out  1, 32  processor state overwrite strobe and value
- `vector_valid`, `vector_addr`  out  1, ADDR_W  redirect fetch
- `nest_depth`  out  $clog2(DEPTH+1)  current nesting level
- `busy`  out  1  state ≠ IDLE
- `stack_full`  out  1  `nest_depth == DEPTH`
- `reti_err`  out  1  pulse: `reti` seen at depth 0

## Operation
- States: IDLE, ARM, ENTER, VECTOR, EXIT. All outputs decode from registered state and latches only.
- IDLE:
  - `reti` with depth>0 → EXIT.
  - `reti` with depth 0 → `reti_err` pulse next cycle, stay IDLE.
  - Otherwise, `irq_valid` with `!stack_full` → ARM; latch `irq_id`, `irq_priority`, `ivt_addr`.
  - `reti` beats `irq_valid` in the same cycle.
- ARM: `irq_valid` low → IDLE (cancelled, no acknowledges). `fetch_ready` high → ENTER. Latched values are frozen while in ARM.
- ENTER (one cycle):
  - Push {`p_state_in`, latched ID} onto the stack; depth+1.
  - `ack_start`=1, `ack_start_id`=latched ID.
  - `p_state_load`=1, `p_state_out`={`p_state_in`[31:9], latched pri, latched ID, gie=0}.
  - Next state: VECTOR.
- VECTOR (one cycle): `vector_valid`=1, `vector_addr`=latched addr → IDLE.
- EXIT (one cycle):
  - `ack_end`=1, `ack_end_id`=ID stored at top of stack.
  - `p_state_load`=1, `p_state_out`=saved state at top; pop; depth−1.
  - Next state: IDLE.
- `reti` arriving outside IDLE is held in a one-bit pending flag and serviced on the next IDLE cycle. A second `reti` while the flag is set is dropped.
- Nesting: the decider already gates on priority, so any `irq_valid` seen in IDLE is accepted if the stack is not full. Stack is LIFO; IDs are restored in reverse order.

## Timing
- Reset (async, `rst_n`=0): state IDLE, depth 0, pending flag 0, every output 0 (`p_state_out`=0, `vector_addr`=0). Stack contents are don't-care.
- Reset mid-handler discards the stack; no `ack_end` is issued.
- Entry latency with `irq_valid` sampled high in IDLE at cycle N and `fetch_ready` high:
  - cycle N+1: ARM.
  - cycle N+2: ENTER outputs (`ack_start` and `p_state_load` together).
  - cycle N+3: `vector_valid`.
- Exit latency: `reti` at N in IDLE → EXIT outputs at N+1.
- All strobes (`ack_start`, `ack_end`, `p_state_load`, `vector_valid`, `reti_err`) are exactly one cycle wide. Never two in a row from the same event.
- `stack_full` blocks acceptance; `irq_valid` simply stays pending.

## Configuration
- `INT_DISPATCH_STATS_EN` defined:
  - Adds output `dispatch_count` (16 bits) and output `max_depth` ($clog2(DEPTH+1) bits).
  - `dispatch_count` increments in ENTER and saturates at 16'hFFFF.
  - `max_depth` is the high-water mark of `nest_depth`.
  - Both reset to 0.
- Undefined: those ports and registers do not exist; behaviour is otherwise identical.

## Test plan
- Single interrupt: `irq_valid`, ID 2, pri 3, addr 200, `fetch_ready`=1, `p_state_in`=32'hF00000FF → `ack_start` with ID 2 at N+2; `p_state_out`=32'hF00000C4; `vector_addr`=200 at N+3; `nest_depth`=1.
- Return: `reti` pulse → `ack_end` with ID 2 and `p_state_out`=32'hF00000FF next cycle; depth 0.
- Nesting: ID 2 entered, then ID 5 entered, then two `reti` → `ack_end_id` 5 then 2; states restored in LIFO order.
- Cancel and boundary: `irq_valid` drops while in ARM with `fetch_ready`=0 → no `ack_start`, back to IDLE. Separately, `reti` and `irq_valid` in the same IDLE cycle → EXIT first, entry afterwards.
- Limits:
  - DEPTH=4 with 4 entries → `stack_full`=1 and a fifth interrupt is held off.
  - `reti` at depth 0 → `reti_err` pulse only.
  - `rst_n` low during VECTOR → all outputs 0 immediately.
- Stats build: 3 dispatches with max nesting 2 → `dispatch_count`=3, `max_depth`=2.

Source files
------------

// File: rtl/interrupt_dispatcher.sv
// -----------------------------------------------------------------------------
// interrupt_dispatcher
//
// Sequences processor entry into and exit from interrupt handlers. A decided
// interrupt is latched, held until the processor reaches an instruction
// boundary, then the live processor state is pushed on a LIFO nesting stack,
// the controller gets a start acknowledge, the processor state is overwritten
// (gie cleared, current ID/priority replaced) and the vector address is
// presented. A return-from-interrupt pops the stack, restores the saved
// state and issues the end acknowledge.
//
// Optional feature macro: INT_DISPATCH_STATS_EN
//   When defined, adds o_dispatch_count (saturating count of handler entries)
//   and o_max_depth (high-water mark of o_nest_depth).
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   i_irq_valid          decided interrupt pending
//   i_irq_id/_priority   pending interrupt ID and priority
//   i_ivt_addr           vector address for i_irq_id
//   i_p_state_in         live processor state: [0] gie, [5:1] ID, [8:6] priority
//   i_fetch_ready        processor at an instruction boundary
//   i_reti               one-cycle pulse: return-from-interrupt executed
//   o_ack_start(_id)     start acknowledge to the controller
//   o_ack_end(_id)       end acknowledge to the controller
//   o_p_state_load/_out  processor state overwrite strobe and value
//   o_vector_valid/_addr fetch redirect
//   o_nest_depth         current nesting level
//   o_busy               dispatcher not idle
//   o_stack_full         nesting stack full, new interrupts held off
//   o_reti_err           pulse: return seen with nothing on the stack
// -----------------------------------------------------------------------------
module interrupt_dispatcher #(
  parameter int ID_W   = 5,
  parameter int PRI_W  = 3,
  parameter int ADDR_W = 28,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_irq_valid,
  input  logic [ID_W-1:0]              i_irq_id,
  input  logic [PRI_W-1:0]             i_irq_priority,
  input  logic [ADDR_W-1:0]            i_ivt_addr,
  input  logic [31:0]                  i_p_state_in,
  input  logic                         i_fetch_ready,
  input  logic                         i_reti,
  output logic                         o_ack_start,
  output logic [ID_W-1:0]              o_ack_start_id,
  output logic                         o_ack_end,
  output logic [ID_W-1:0]              o_ack_end_id,
  output logic                         o_p_state_load,
  output logic [31:0]                  o_p_state_out,
  output logic                         o_vector_valid,
  output logic [ADDR_W-1:0]            o_vector_addr,
  output logic [$clog2(DEPTH+1)-1:0]   o_nest_depth,
  output logic                         o_busy,
  output logic                         o_stack_full,
  output logic                         o_reti_err
`ifdef INT_DISPATCH_STATS_EN
  ,
  output logic [15:0]                  o_dispatch_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_max_depth
`endif
);

  localparam int DW    = $clog2(DEPTH + 1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LOW_W = 1 + ID_W + PRI_W;   // gie + ID + priority field
  localparam logic [DW-1:0] DEPTH_D = DW'(DEPTH);
  localparam logic [DW-1:0] ZERO_D  = DW'(0);
  localparam logic [DW-1:0] ONE_D   = DW'(1);
  localparam logic [IW-1:0] ONE_I   = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_ENTER  = 3'd2,
    S_VECTOR = 3'd3,
    S_EXIT   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DW-1:0]       r_depth;
  logic                r_reti_pend;
  logic [ID_W-1:0]     r_lat_id;
  logic [PRI_W-1:0]    r_lat_pri;
  logic [ADDR_W-1:0]   r_lat_addr;
  logic [31:0]         r_save_state;
  logic [31:0]         r_stk_state [DEPTH];
  logic [ID_W-1:0]     r_stk_id    [DEPTH];

  logic                r_ack_start;
  logic [ID_W-1:0]     r_ack_start_id;
  logic                r_ack_end;
  logic [ID_W-1:0]     r_ack_end_id;
  logic                r_p_state_load;
  logic [31:0]         r_p_state_out;
  logic                r_vector_valid;
  logic [ADDR_W-1:0]   r_vector_addr;
  logic                r_reti_err;

  logic                w_reti_eff;
  logic                w_full;
  logic                w_accept;
  logic                w_err;
  logic                w_go_enter;
  logic                w_go_exit;
  logic                w_go_vector;
  logic [IW-1:0]       w_top_idx;
  logic [IW-1:0]       w_push_idx;
  logic [31:0]         w_pso_enter;

  // A return seen while busy is remembered and serviced on the next idle cycle.
  assign w_reti_eff  = i_reti | r_reti_pend;
  assign w_full      = (r_depth == DEPTH_D);
  // Low IW bits of depth-1 equal (low IW bits of depth)-1 modulo 2^IW.
  assign w_top_idx   = r_depth[IW-1:0] - ONE_I;
  assign w_push_idx  = r_depth[IW-1:0];
  assign w_pso_enter = {i_p_state_in[31:LOW_W], r_lat_pri, r_lat_id, 1'b0};

  // Next-state decode; a return beats a new interrupt in the same idle cycle.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_reti_eff) begin
          if (r_depth != ZERO_D) begin
            w_next = S_EXIT;
          end else begin
            w_err = 1'b1;
          end
        end else if (i_irq_valid && !w_full) begin
          w_next   = S_ARM;
          w_accept = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ARM: begin
        if (!i_irq_valid) begin
          w_next = S_IDLE;
        end else if (i_fetch_ready) begin
          w_next = S_ENTER;
        end else begin
          w_next = S_ARM;
        end
      end
      S_ENTER:  w_next = S_VECTOR;
      S_VECTOR: w_next = S_IDLE;
      S_EXIT:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_go_enter  = (w_next == S_ENTER);
  assign w_go_exit   = (w_next == S_EXIT);
  assign w_go_vector = (w_next == S_VECTOR);

  // State register, nesting depth, pending-return flag and request latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_depth      <= ZERO_D;
      r_reti_pend  <= 1'b0;
      r_lat_id     <= {ID_W{1'b0}};
      r_lat_pri    <= {PRI_W{1'b0}};
      r_lat_addr   <= {ADDR_W{1'b0}};
      r_save_state <= 32'h0000_0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_reti_pend <= 1'b0;
      end else if (i_reti) begin
        r_reti_pend <= 1'b1;
      end
      if (w_accept) begin
        r_lat_id   <= i_irq_id;
        r_lat_pri  <= i_irq_priority;
        r_lat_addr <= i_ivt_addr;
      end
      // The state pushed is the one also used to build the ENTER overwrite.
      if (w_go_enter) begin
        r_save_state <= i_p_state_in;
      end
      if (r_state == S_ENTER) begin
        r_depth <= r_depth + ONE_D;
      end else if (r_state == S_EXIT) begin
        r_depth <= r_depth - ONE_D;
      end
    end
  end

  // Nesting stack storage; contents are meaningless above the current depth.
  always_ff @(posedge clk) begin
    if (r_state == S_ENTER) begin
      r_stk_state[w_push_idx] <= r_save_state;
      r_stk_id[w_push_idx]    <= r_lat_id;
    end
  end

  // Registered strobes and payloads, set on the edge that enters each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_start    <= 1'b0;
      r_ack_start_id <= {ID_W{1'b0}};
      r_ack_end      <= 1'b0;
      r_ack_end_id   <= {ID_W{1'b0}};
      r_p_state_load <= 1'b0;
      r_p_state_out  <= 32'h0000_0000;
      r_vector_valid <= 1'b0;
      r_vector_addr  <= {ADDR_W{1'b0}};
      r_reti_err     <= 1'b0;
    end else begin
      r_ack_start    <= w_go_enter;
      r_ack_end      <= w_go_exit;
      r_p_state_load <= w_go_enter | w_go_exit;
      r_vector_valid <= w_go_vector;
      r_reti_err     <= w_err;
      if (w_go_enter) begin
        r_ack_start_id <= r_lat_id;
        r_p_state_out  <= w_pso_enter;
      end else if (w_go_exit) begin
        r_ack_end_id  <= r_stk_id[w_top_idx];
        r_p_state_out <= r_stk_state[w_top_idx];
      end
      if (w_go_vector) begin
        r_vector_addr <= r_lat_addr;
      end
    end
  end

`ifdef INT_DISPATCH_STATS_EN
  logic [15:0]   r_dispatch_count;
  logic [DW-1:0] r_max_depth;

  // Saturating entry counter and nesting high-water mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dispatch_count <= 16'h0000;
      r_max_depth      <= ZERO_D;
    end else begin
      if ((r_state == S_ENTER) && (r_dispatch_count != 16'hFFFF)) begin
        r_dispatch_count <= r_dispatch_count + 16'h0001;
      end
      if (r_depth > r_max_depth) begin
        r_max_depth <= r_depth;
      end
    end
  end

  assign o_dispatch_count = r_dispatch_count;
  assign o_max_depth      = r_max_depth;
`endif

  assign o_ack_start    = r_ack_start;
  assign o_ack_start_id = r_ack_start_id;
  assign o_ack_end      = r_ack_end;
  assign o_ack_end_id   = r_ack_end_id;
  assign o_p_state_load = r_p_state_load;
  assign o_p_state_out  = r_p_state_out;
  assign o_vector_valid = r_vector_valid;
  assign o_vector_addr  = r_vector_addr;
  assign o_nest_depth   = r_depth;
  assign o_busy         = (r_state != S_IDLE);
  assign o_stack_full   = w_full;
  assign o_reti_err     = r_reti_err;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// -----------------------------------------------------------------------------
// Self-checking bench for interrupt_dispatcher: a table of cycle vectors,
// hand-written multi-cycle sequences (nesting, full stack, return/interrupt
// collision, reset mid-handler) and randomized traffic against a reference
// model built from a queue-based stack and scheduled expectations.
// -----------------------------------------------------------------------------
module tb_interrupt_dispatcher;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_valid = 1'b0;
  logic [4:0]  irq_id = 5'd0;
  logic [2:0]  irq_priority = 3'd0;
  logic [27:0] ivt_addr = 28'd0;
  logic [31:0] p_state_in = 32'd0;
  logic        fetch_ready = 1'b0;
  logic        reti = 1'b0;
  logic        ack_start, ack_end, p_state_load, vector_valid, busy, stack_full, reti_err;
  logic [4:0]  ack_start_id, ack_end_id;
  logic [31:0] p_state_out;
  logic [27:0] vector_addr;
  logic [2:0]  nest_depth;
`ifdef INT_DISPATCH_STATS_EN
  logic [15:0] dispatch_count;
  logic [2:0]  max_depth;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  interrupt_dispatcher #(.ID_W(5), .PRI_W(3), .ADDR_W(28), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_irq_valid(irq_valid), .i_irq_id(irq_id), .i_irq_priority(irq_priority),
    .i_ivt_addr(ivt_addr), .i_p_state_in(p_state_in), .i_fetch_ready(fetch_ready),
    .i_reti(reti),
    .o_ack_start(ack_start), .o_ack_start_id(ack_start_id),
    .o_ack_end(ack_end), .o_ack_end_id(ack_end_id),
    .o_p_state_load(p_state_load), .o_p_state_out(p_state_out),
    .o_vector_valid(vector_valid), .o_vector_addr(vector_addr),
    .o_nest_depth(nest_depth), .o_busy(busy), .o_stack_full(stack_full),
    .o_reti_err(reti_err)
`ifdef INT_DISPATCH_STATS_EN
    , .o_dispatch_count(dispatch_count), .o_max_depth(max_depth)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    irq_valid = 1'b0; fetch_ready = 1'b0; reti = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        v; logic [4:0] id; logic [2:0] pri; logic [27:0] addr;
    logic [31:0] ps; logic fr; logic rt;
    logic        xs; logic xe; logic [4:0] xid; logic xld; logic [31:0] xpso;
    logic        xvv; logic [27:0] xva; logic [2:0] xdep; logic xbusy; logic xerr;
  } vec_t;
  vec_t tbl[12];

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] st; logic [4:0] id; } frame_t;
  typedef struct {
    bit sched; bit ack_s; bit ack_e; logic [4:0] sid; logic [4:0] eid;
    bit ld; logic [31:0] pso; bit vv; logic [27:0] va; bit err; int dep;
  } exp_t;
  frame_t      stk[$];
  exp_t        ring[4];
  bit          m_wait, m_pend;
  int          m_free;
  logic [4:0]  l_id;
  logic [2:0]  l_pri;
  logic [27:0] l_addr;

  task automatic m_clear();
    stk.delete();
    m_wait = 1'b0; m_pend = 1'b0; m_free = 0;
    for (int k = 0; k < 4; k++) ring[k] = '{default: 0};
  endtask

  // Inputs of cycle c decide what happens in cycle c+1 (and c+2 for entry).
  function automatic void m_step(input int c);
    frame_t f;
    exp_t   e;
    if (!m_wait && c >= m_free) begin
      if (reti || m_pend) begin
        m_pend = 1'b0;
        e = '{default: 0};
        e.sched = 1'b1;
        if (stk.size() > 0) begin
          f = stk.pop_back();
          e.ack_e = 1'b1; e.eid = f.id; e.ld = 1'b1; e.pso = f.st;
          e.dep = stk.size() + 1;
          m_free = c + 2;
        end else begin
          e.err = 1'b1; e.dep = 0;
        end
        ring[(c + 1) % 4] = e;
      end else if (irq_valid && stk.size() < DEPTH) begin
        m_wait = 1'b1; l_id = irq_id; l_pri = irq_priority; l_addr = ivt_addr;
      end
    end else begin
      if (reti) m_pend = 1'b1;
      if (m_wait && c >= m_free) begin
        if (!irq_valid) begin
          m_wait = 1'b0;
        end else if (fetch_ready) begin
          m_wait = 1'b0;
          e = '{default: 0};
          e.sched = 1'b1; e.ack_s = 1'b1; e.sid = l_id; e.ld = 1'b1;
          e.pso = {p_state_in[31:9], l_pri, l_id, 1'b0};
          e.dep = stk.size();
          ring[(c + 1) % 4] = e;
          stk.push_back('{st: p_state_in, id: l_id});
          e = '{default: 0};
          e.sched = 1'b1; e.vv = 1'b1; e.va = l_addr; e.dep = stk.size();
          ring[(c + 2) % 4] = e;
          m_free = c + 3;
        end
      end
    end
  endfunction

  task automatic m_check(input int t);
    exp_t e;
    int   edep;
    bit   ebusy;
    e     = ring[t % 4];
    edep  = e.sched ? e.dep : stk.size();
    ebusy = m_wait || (t < m_free);
    chk("rnd_ack_start", ack_start, e.ack_s);
    chk("rnd_ack_end", ack_end, e.ack_e);
    chk("rnd_load", p_state_load, e.ld);
    chk("rnd_vector_valid", vector_valid, e.vv);
    chk("rnd_reti_err", reti_err, e.err);
    chk("rnd_depth", nest_depth, edep);
    chk("rnd_busy", busy, ebusy);
    chk("rnd_full", stack_full, edep == DEPTH);
    if (e.ack_s) chk("rnd_start_id", ack_start_id, e.sid);
    if (e.ack_e) chk("rnd_end_id", ack_end_id, e.eid);
    if (e.ld) chk("rnd_pso", p_state_out, e.pso);
    if (e.vv) chk("rnd_vaddr", vector_addr, e.va);
    ring[t % 4] = '{default: 0};
  endtask

  // ---------------- hand-sequence helpers ----------------
  task automatic enter(input logic [4:0] id, input logic [2:0] pri,
                       input logic [27:0] addr, input logic [31:0] ps);
    irq_valid = 1'b1; irq_id = id; irq_priority = pri; ivt_addr = addr;
    p_state_in = ps; fetch_ready = 1'b1;
    tick();
    chk("enter_arm_busy", busy, 1'b1);
    chk("enter_arm_no_ack", ack_start, 1'b0);
    tick();
    chk("enter_ack_start", ack_start, 1'b1);
    chk("enter_start_id", ack_start_id, id);
    chk("enter_load", p_state_load, 1'b1);
    chk("enter_pso", p_state_out, {ps[31:9], pri, id, 1'b0});
    irq_valid = 1'b0; fetch_ready = 1'b0;
    tick();
    chk("enter_vector_valid", vector_valid, 1'b1);
    chk("enter_vaddr", vector_addr, addr);
    chk("enter_ack_once", ack_start, 1'b0);
    tick();
  endtask

  task automatic leave(input logic [4:0] id, input logic [31:0] ps);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    chk("exit_ack_end", ack_end, 1'b1);
    chk("exit_end_id", ack_end_id, id);
    chk("exit_load", p_state_load, 1'b1);
    chk("exit_pso", p_state_out, ps);
    tick();
    chk("exit_ack_once", ack_end, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit found;
    int cyc;
    //          v  id  pri addr  ps            fr rt  xs xe xid ld xpso          vv xva  dep bsy err
    tbl[0]  = '{1, 2,  3, 200, 32'hF00000FF, 1, 0,  0, 0, 0, 0, 32'h0,        0, 0,   0, 1, 0};
    tbl[1]  = '{1, 2,  3, 200, 32'hF00000FF, 1, 0,  1, 0, 2, 1, 32'hF00000C4, 0, 0,   0, 1, 0};
    tbl[2]  = '{0, 2,  3, 200, 32'hF00000FF, 0, 0,  0, 0, 0, 0, 32'h0,        1, 200, 1, 1, 0};
    tbl[3]  = '{0, 0,  0, 0,   32'hF00000FF, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0,   1, 0, 0};
    tbl[4]  = '{0, 0,  0, 0,   32'hF00000FF, 0, 1,  0, 1, 2, 1, 32'hF00000FF, 0, 0,   1, 1, 0};
    tbl[5]  = '{0, 0,  0, 0,   32'hF00000FF, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 0};
    tbl[6]  = '{0, 0,  0, 0,   32'hF00000FF, 0, 1,  0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 1};
    tbl[7]  = '{0, 0,  0, 0,   32'hF00000FF, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 0};
    tbl[8]  = '{1, 7,  1, 77,  32'hF00000FF, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0,   0, 1, 0};
    tbl[9]  = '{1, 7,  1, 77,  32'hF00000FF, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0,   0, 1, 0};
    tbl[10] = '{0, 7,  1, 77,  32'hF00000FF, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 0};
    tbl[11] = '{0, 0,  0, 0,   32'hF00000FF, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 0};

    // Reset values
    quiet();
    tick();
    chk("rst_ack_start", ack_start, 1'b0);
    chk("rst_ack_end", ack_end, 1'b0);
    chk("rst_load", p_state_load, 1'b0);
    chk("rst_pso", p_state_out, 32'h0);
    chk("rst_vvalid", vector_valid, 1'b0);
    chk("rst_vaddr", vector_addr, 28'h0);
    chk("rst_depth", nest_depth, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", stack_full, 1'b0);
    chk("rst_err", reti_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Table: single interrupt, return, reti at depth 0, cancel in ARM
    for (int k = 0; k < 12; k++) begin
      irq_valid = tbl[k].v; irq_id = tbl[k].id; irq_priority = tbl[k].pri;
      ivt_addr = tbl[k].addr; p_state_in = tbl[k].ps;
      fetch_ready = tbl[k].fr; reti = tbl[k].rt;
      tick();
      chk($sformatf("tbl%0d_ack_start", k), ack_start, tbl[k].xs);
      chk($sformatf("tbl%0d_ack_end", k), ack_end, tbl[k].xe);
      chk($sformatf("tbl%0d_load", k), p_state_load, tbl[k].xld);
      chk($sformatf("tbl%0d_vvalid", k), vector_valid, tbl[k].xvv);
      chk($sformatf("tbl%0d_depth", k), nest_depth, tbl[k].xdep);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].xbusy);
      chk($sformatf("tbl%0d_err", k), reti_err, tbl[k].xerr);
      if (tbl[k].xs) chk($sformatf("tbl%0d_start_id", k), ack_start_id, tbl[k].xid);
      if (tbl[k].xe) chk($sformatf("tbl%0d_end_id", k), ack_end_id, tbl[k].xid);
      if (tbl[k].xld) chk($sformatf("tbl%0d_pso", k), p_state_out, tbl[k].xpso);
      if (tbl[k].xvv) chk($sformatf("tbl%0d_vaddr", k), vector_addr, tbl[k].xva);
    end
    quiet();

    // Nesting: 2 then 5, returns in LIFO order; a third dispatch for stats
    do_reset();
    enter(5'd2, 3'd3, 28'd200, 32'hF00000FF);
    enter(5'd5, 3'd6, 28'd500, 32'hF00000C4);
    chk("nest_depth2", nest_depth, 3'd2);
    leave(5'd5, 32'hF00000C4);
    leave(5'd2, 32'hF00000FF);
    chk("nest_depth0", nest_depth, 3'd0);
    enter(5'd9, 3'd1, 28'd900, 32'h12345601);
    leave(5'd9, 32'h12345601);
`ifdef INT_DISPATCH_STATS_EN
    chk("stats_count", dispatch_count, 16'd3);
    chk("stats_max_depth", max_depth, 3'd2);
`endif

    // Full stack holds off a fifth interrupt
    do_reset();
    for (int k = 1; k <= 4; k++) enter(5'(k), 3'(k), 28'(k * 16), 32'hA0000000 | 32'(k));
    chk("full_flag", stack_full, 1'b1);
    chk("full_depth", nest_depth, 3'd4);
    irq_valid = 1'b1; irq_id = 5'd20; fetch_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_held_busy", busy, 1'b0);
      chk("full_held_ack", ack_start, 1'b0);
    end
    quiet();
    for (int k = 4; k >= 1; k--) leave(5'(k), 32'hA0000000 | 32'(k));
    chk("full_cleared", stack_full, 1'b0);

    // reti and irq_valid in the same idle cycle: exit first, then entry
    enter(5'd6, 3'd2, 28'd60, 32'h00000FFF);
    reti = 1'b1; irq_valid = 1'b1; irq_id = 5'd11; irq_priority = 3'd2;
    ivt_addr = 28'd1234; fetch_ready = 1'b1;
    tick();
    reti = 1'b0;
    chk("coll_ack_end", ack_end, 1'b1);
    chk("coll_end_id", ack_end_id, 5'd6);
    chk("coll_no_start", ack_start, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (ack_start) found = 1'b1;
    end
    chk("coll_entry_seen", found, 1'b1);
    chk("coll_start_id", ack_start_id, 5'd11);
    quiet();
    tick(); tick();

    // Reset during VECTOR clears outputs at once; no ack_end afterwards
    do_reset();
    irq_valid = 1'b1; irq_id = 5'd3; irq_priority = 3'd4; ivt_addr = 28'hABCDEF;
    p_state_in = 32'h55555555; fetch_ready = 1'b1;
    tick(); tick();
    quiet();
    tick();
    chk("rv_vvalid_before", vector_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rv_vvalid", vector_valid, 1'b0);
    chk("rv_vaddr", vector_addr, 28'h0);
    chk("rv_pso", p_state_out, 32'h0);
    chk("rv_load", p_state_load, 1'b0);
    chk("rv_depth", nest_depth, 3'd0);
    chk("rv_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    chk("rv_reti_err", reti_err, 1'b1);
    chk("rv_no_ack_end", ack_end, 1'b0);
    tick();
    chk("rv_err_once", reti_err, 1'b0);

    // Randomized traffic against the reference model
    do_reset();
    m_clear();
    cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      irq_valid    = ($urandom_range(0, 9) < 6);
      irq_id       = 5'($urandom);
      irq_priority = 3'($urandom);
      ivt_addr     = 28'($urandom);
      fetch_ready  = ($urandom_range(0, 3) != 0);
      reti         = ($urandom_range(0, 9) < 2);
      if (!m_wait && cyc >= m_free) p_state_in = $urandom;
      m_step(cyc);
      tick();
      cyc++;
      m_check(cyc);
    end
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
